// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter slice.
//   DATA_W_DEF : default requester / output word width
//   NUM_REQ    : number of requesters (tied to the 4-input mux)
//   sel_t      : 2-bit requester index / mux select
//   data_t     : one requester word at the default width
package mux_arb_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int NUM_REQ    = 4;

    typedef logic [1:0]            sel_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage : mux_arb_pkg

// File: rtl/mux_4to1.sv
// Plain 4-input multiplexer for the requester datapath.
//   d0..d3 : input words
//   sel    : select, 0..3 picks d0..d3
//   y      : selected word
module mux_4to1 #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule : mux_4to1

// File: rtl/mux_rr_arbiter_pick4.sv
// Combinational round-robin priority search over four requesters.
//   elig      : eligible requester bits
//   ptr       : index with highest priority this cycle
//   winner    : first eligible index at or after ptr (wrapping), 0 if none
//   any_valid : at least one eligible requester
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [3:0] elig,
    input  sel_t       ptr,
    output sel_t       winner,
    output logic       any_valid
);

    // Walk offsets from the farthest to the nearest; the last hit is the
    // closest to ptr, so it takes priority.
    always_comb begin
        sel_t idx;
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (elig[idx]) begin
                winner = idx;
            end
        end
    end

    assign any_valid = |elig;

endmodule : rr_pick4

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a 4-input mux into a one-entry output register.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid[3:0]      : per-requester valid
//   req_data0..3        : requester words (mux inputs d0..d3)
//   req_mask[3:0]       : 1 excludes that requester from arbitration
//   req_ready[3:0]      : one-hot (or zero) accept for this cycle
//   out_valid/out_ready : output register handshake
//   out_data, out_src   : held word and the requester index it came from
//   mux_sel             : current mux select, for debug
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Requester i's word moves when req_valid[i] && req_ready[i];
// the held word leaves when out_valid && out_ready. ready is never a
// function of the same interface's own ready, and valid from a requester
// may depend on nothing from this block.
//
// State is implicit in out_valid: EMPTY (0) and FULL (1).
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_REQ = mux_arb_pkg::NUM_REQ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req_valid,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    input  logic [DATA_W-1:0] req_data3,
    input  logic [3:0]        req_mask,
    output logic [3:0]        req_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    input  logic              out_ready,
    output logic [1:0]        mux_sel
);

    if (NUM_REQ != 4) begin : g_bad_num_req
        $error("mux_rr_arbiter: NUM_REQ must be 4 to match the 4-input mux");
    end

    sel_t              ptr;
    sel_t              sel_q;
    sel_t              winner;
    logic              any_valid;
    logic [3:0]        elig;
    logic              can_accept;
    logic              grant;
    logic [DATA_W-1:0] mux_y;

    assign elig = req_valid & ~req_mask;

    rr_pick4 u_pick (
        .elig      (elig),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Register is free if empty or its word leaves on this same edge.
    assign can_accept = !out_valid || out_ready;
    assign grant      = can_accept && any_valid;

    // With nobody eligible the select parks on the previous winner.
    assign mux_sel   = any_valid ? winner : sel_q;
    assign req_ready = grant ? (4'b0001 << winner) : 4'b0000;

    mux_4to1 #(.DATA_W(DATA_W)) u_mux (
        .d0  (req_data0),
        .d1  (req_data1),
        .d2  (req_data2),
        .d3  (req_data3),
        .sel (mux_sel),
        .y   (mux_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            ptr       <= 2'd0;
            sel_q     <= 2'd0;
        end else begin
            if (any_valid) begin
                sel_q <= winner;
            end
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= mux_y;
                out_src   <= winner;
                ptr       <= winner + 2'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : mux_rr_arbiter

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [W-1:0] req_data0, req_data1, req_data2, req_data3;
    logic [3:0]   req_mask;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;
    logic [1:0]   mux_sel;

    always #5 clk = ~clk;

    mux_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
        .req_mask  (req_mask),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .mux_sel   (mux_sel)
    );

    // ---------------- scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one edge; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set_data(input logic [W-1:0] a, b, c, d);
        req_data0 = a;
        req_data1 = b;
        req_data2 = c;
        req_data3 = d;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        step();
        #2 rst = 1'b0;
        settle();
    endtask

    // ---------------- stimulus ----------------
    int   order[5] = '{0, 1, 2, 3, 0};
    int   mord[4]  = '{0, 2, 3, 0};
    logic [W-1:0] expw;

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0;
        req_mask  = 4'b0;
        out_ready = 1'b0;
        set_data(4'h0, 4'h0, 4'h0, 4'h0);
        settle();

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  4'h0);
        check("rst_out_src",   out_src,   2'd0);
        check("rst_req_ready", req_ready, 4'b0);
        check("rst_ptr",       dut.ptr,   2'd0);
        step();
        #2 rst = 1'b0;
        settle();

        // Single requester
        req_valid = 4'b0100;
        set_data(4'h0, 4'h0, 4'hA, 4'h0);
        out_ready = 1'b1;
        settle();
        check("single_ready",   req_ready, 4'b0100);
        check("single_mux_sel", mux_sel,   2'd2);
        step();
        req_valid = 4'b0000;
        check("single_valid", out_valid, 1'b1);
        check("single_data",  out_data,  4'hA);
        check("single_src",   out_src,   2'd2);
        check("single_ptr",   dut.ptr,   2'd3);
        step();
        check("single_drain_valid", out_valid, 1'b0);
        check("single_drain_hold",  out_data,  4'hA);

        // Reset mid-run with a held word
        req_valid = 4'b0001;
        set_data(4'h5, 4'h0, 4'h0, 4'h0);
        out_ready = 1'b0;
        step();
        req_valid = 4'b0000;
        check("midrst_pre_valid", out_valid, 1'b1);
        check("midrst_pre_data",  out_data,  4'h5);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_data",  out_data,  4'h0);
        check("midrst_ptr",   dut.ptr,   2'd0);
        check("midrst_ready", req_ready, 4'b0);
        step();
        #2 rst = 1'b0;
        settle();
        check("idle_ready", req_ready, 4'b0);

        // All four valid, continuous
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        settle();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_ready%0d", i), req_ready, 4'b0001 << order[i]);
            exp_q.push_back(W'(order[i] + 1));
            step();
            expw = exp_q.pop_front();
            check($sformatf("rr_valid%0d", i), out_valid, 1'b1);
            check($sformatf("rr_data%0d", i),  out_data,  expw);
            check($sformatf("rr_src%0d", i),   out_src,   order[i]);
        end
        req_valid = 4'b0000;
        step();
        check("rr_drain_valid", out_valid, 1'b0);
        check("rr_ptr",         dut.ptr,   2'd1);

        // Backpressure: ptr=1
        req_valid = 4'b1111;
        settle();
        check("bp_first_ready", req_ready, 4'b0010);
        step();
        out_ready = 1'b0;
        check("bp_first_data", out_data, 4'h2);
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("bp_ready%0d", i), req_ready, 4'b0);
            step();
            check($sformatf("bp_data%0d", i),  out_data,  4'h2);
            check($sformatf("bp_src%0d", i),   out_src,   2'd1);
            check($sformatf("bp_valid%0d", i), out_valid, 1'b1);
            check($sformatf("bp_ptr%0d", i),   dut.ptr,   2'd2);
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_ready", req_ready, 4'b0100);
        step();
        check("bp_next_data", out_data, 4'h3);
        check("bp_next_src",  out_src,  2'd2);
        req_valid = 4'b0000;
        step();

        // Mask requester 1, starting from ptr=0
        pulse_reset();
        req_valid = 4'b1111;
        req_mask  = 4'b0010;
        settle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mask_ready%0d", i), req_ready, 4'b0001 << mord[i]);
            step();
            check($sformatf("mask_src%0d", i),  out_src,  mord[i]);
            check($sformatf("mask_data%0d", i), out_data, W'(mord[i] + 1));
        end
        // Only the masked requester is valid: no grant, select parks on last winner
        req_valid = 4'b0010;
        settle();
        check("mask_only_ready", req_ready, 4'b0);
        check("mask_only_sel",   mux_sel,   2'd0);
        step();
        check("mask_only_valid", out_valid, 1'b0);
        check("mask_only_ptr",   dut.ptr,   2'd1);
        req_mask  = 4'b0000;

        // Pointer wrap and sparse requests
        set_data(4'hC, 4'h0, 4'h7, 4'h9);
        req_valid = 4'b0100;
        settle();
        check("wrap_pre_ready", req_ready, 4'b0100);
        step();
        check("wrap_pre_ptr", dut.ptr, 2'd3);
        req_valid = 4'b1001;
        settle();
        check("wrap_ready3", req_ready, 4'b1000);
        step();
        check("wrap_src3",  out_src,  2'd3);
        check("wrap_data3", out_data, 4'h9);
        check("wrap_ptr0",  dut.ptr,  2'd0);
        settle();
        check("wrap_ready0", req_ready, 4'b0001);
        step();
        check("wrap_src0",   out_src,   2'd0);
        check("wrap_data0",  out_data,  4'hC);
        check("wrap_valid0", out_valid, 1'b1);
        check("wrap_ptr1",   dut.ptr,   2'd1);
        req_valid = 4'b0000;
        step();
        check("final_drain", out_valid, 1'b0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_rr_arbiter

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4-input, 4-bit mux datapath.
- Four requesters each present a 4-bit word with a valid/ready handshake. The block picks one winner per accept cycle and drives the mux select, so the winner's word passes through the mux.
- The muxed word is captured in a one-entry output register with a valid/ready handshake toward the downstream consumer.
- Sits between the requester sources and the shared consumer; the mux itself is instantiated inside.

Parameters:
- DATA_W, 4, width of each requester word and of out_data. Must equal the mux data width.
- NUM_REQ, 4, number of requesters. Fixed at 4 because the mux has 4 inputs; any other value is a compile-time error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  4  per-requester valid; bit i belongs to requester i.
- req_data0..req_data3  input  DATA_W each  requester words, wired to mux inputs d0..d3.
- req_mask  input  4  bit i = 1 excludes requester i from arbitration; sampled every cycle.
- req_ready  output  4  one-hot or zero; bit i high means requester i's word is accepted this cycle.
- out_valid  output  1  output register holds a valid word.
- out_data  output  DATA_W  registered muxed word.
- out_src  output  2  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- mux_sel  output  2  current combinational select to the mux; debug visibility.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, priority pointer ptr=0, req_ready=0. A reset mid-transfer drops the held word; no replay.
- Eligible set: E = req_valid & ~req_mask.
- Winner: first set bit of E, searching ptr, ptr+1, ..., ptr+3 mod 4. mux_sel is the winner, or holds its last value when E=0.
- Accept condition: can_accept = !out_valid || out_ready, i.e. the register is empty or being drained this cycle.
- Grant: req_ready[winner] = can_accept && (E != 0). All other req_ready bits are 0. req_ready is combinational; it never depends on req_ready from another requester.
- On grant, at the clock edge:
  - out_data <= mux output (that requester's word)
  - out_src <= winner
  - out_valid <= 1
  - ptr <= winner+1 mod 4
- Drain without a new grant: out_valid <= 0. out_data and out_src hold their values.
- Back-to-back: drain and new grant in the same cycle give out_valid=1 continuously, one word per cycle.
- Latency: a word granted in cycle N is visible on out_data in cycle N+1.
- Backpressure: while out_valid=1 and out_ready=0, req_ready=0. out_data and out_src are stable. ptr is unchanged.
- Fairness: each requester with E[i] continuously asserted is granted within 4 accept cycles.
- Masked requester: never granted, even if it is the only one valid. ptr does not skip past it; the mask only gates eligibility.
- No eligible requester: no state change except a drain.
- Pointer wrap: a grant to requester 3 sets ptr=0.
- States are implicit: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on drain with no grant.
  - FULL -> FULL on drain with grant, or on stall.

Decomposition:
- Shared package mux_arb_pkg holds:
  - DATA_W_DEF = 4
  - NUM_REQ = 4
  - typedef sel_t = logic [1:0]
  - typedef data_t = logic [DATA_W-1:0]
- Sub-module rr_pick4: a purely combinational round-robin priority search over (E, ptr) returning winner and any_valid. Reusable and unit-testable.
- mux_4to1 is instantiated unchanged for the datapath.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst mid-run with out_valid=1; hold req_valid=0.
  - Required: out_valid=0, out_data=0, ptr=0 immediately on assert; req_ready=0 throughout.
- Single requester:
  - Stimulus: req_valid=4'b0100, req_data2=4'hA, out_ready=1.
  - Required: req_ready=4'b0100 in cycle N; out_valid=1, out_data=4'hA, out_src=2 in cycle N+1.
- All four valid, continuous:
  - Stimulus: data 1,2,3,4 on requesters 0..3; out_ready=1.
  - Required: grants in order 0,1,2,3,0; out_data sequence 1,2,3,4,1; out_valid never drops.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after the first grant.
  - Required: req_ready=0 and out_data/out_src stable for those 3 cycles; when out_ready rises, the next grant occurs in the same cycle.
- Mask:
  - Stimulus: req_valid=4'b1111, req_mask=4'b0010.
  - Required: grant sequence 0,2,3,0; requester 1 is never granted.
- Pointer wrap and sparse requests:
  - Stimulus: ptr=3 after a grant to requester 2; then req_valid=4'b1001.
  - Required: requester 3 wins first; then ptr=0 and requester 0 wins.
